// File: rtl/ibert_pkg.sv
// Shared constants and helpers for the requantizing FIFO drain stage.
// The saturation helper works on a wide signed value so callers of any width can reuse it.
package ibert_pkg;

  localparam int DRAIN_LAT = 3;

  typedef enum logic {
    RND_TRUNC,
    RND_HALF_UP
  } round_mode_e;

  localparam round_mode_e ROUND_MODE = RND_HALF_UP;

  // Clamp a signed value into the range of a width-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/requant_out_q.sv
// Circular output queue for requantized results, with a valid/ready pop side.
// Storage is not reset; only pointers and count are, and out_data reads zero when empty.
module requant_out_q #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic signed [W-1:0]          wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [W-1:0]          out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic signed [W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_next(wr_ptr);
      if (pop)   rd_ptr <= ptr_next(rd_ptr);
      // A write and a pop in the same cycle leave the occupancy unchanged.
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_requant_drain.sv
// Drains the signed accumulator FIFO and requantizes each word (scale, round, shift, saturate).
// Pops are only issued when a queue slot is guaranteed, so backpressure never drops data.
import ibert_pkg::*;

module fifo_requant_drain #(
  parameter int D_W      = 32,
  parameter int M_W      = 16,
  parameter int O_W      = 8,
  parameter int OQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic [D_W-1:0]        fifo_data,
  input  logic [M_W-1:0]        cfg_mult,
  input  logic [4:0]            cfg_shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [O_W-1:0] out_data,
  output logic                  busy
);

  localparam int P_W = D_W + M_W + 1;
  localparam int C_W = $clog2(DRAIN_LAT + 1);
  localparam int Q_W = $clog2(OQ_DEPTH + 1);

  logic [C_W-1:0]        inflight;
  logic [Q_W-1:0]        q_count;
  logic                  rd_d;
  logic                  p_valid;
  logic signed [P_W-1:0] p_reg;
  logic signed [P_W-1:0] rnd;
  logic signed [P_W-1:0] r_val;
  logic signed [O_W-1:0] q_wr_data;

  // Reset gates the pop so a word is never pulled from the FIFO while it is being cleared.
  assign fifo_read = !rst && !fifo_empty &&
                     ((32'(inflight) + 32'(q_count)) < OQ_DEPTH);
  assign busy      = (inflight != '0) || (q_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d     <= 1'b0;
      p_valid  <= 1'b0;
      p_reg    <= '0;
      inflight <= '0;
    end else begin
      rd_d    <= fifo_read;
      p_valid <= rd_d;
      if (rd_d)
        p_reg <= P_W'($signed(fifo_data)) * P_W'($signed({1'b0, cfg_mult}));
      case ({fifo_read, p_valid})
        2'b10:   inflight <= inflight + C_W'(1);
        2'b01:   inflight <= inflight - C_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Half-LSB bias before the arithmetic shift rounds ties toward +inf.
  always_comb begin
    rnd = '0;
    if (ROUND_MODE == RND_HALF_UP && cfg_shift != 5'd0)
      rnd = P_W'(1) << (cfg_shift - 5'd1);
    r_val     = (p_reg + rnd) >>> cfg_shift;
    q_wr_data = O_W'(sat_signed(64'(r_val), O_W));
  end

  requant_out_q #(
    .DEPTH (OQ_DEPTH),
    .W     (O_W)
  ) u_out_q (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (p_valid),
    .wr_data   (q_wr_data),
    .count     (q_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_fifo_requant_drain.sv
// Directed self-checking bench for fifo_requant_drain with a behavioural upstream FIFO
// and an in-order scoreboard of expected requantized results.
module tb_fifo_requant_drain;

  localparam int D_W      = 32;
  localparam int M_W      = 16;
  localparam int O_W      = 8;
  localparam int OQ_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  fifo_empty = 1'b1;
  logic                  fifo_read;
  logic [D_W-1:0]        fifo_data = '0;
  logic [M_W-1:0]        cfg_mult;
  logic [4:0]            cfg_shift;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [O_W-1:0] out_data;
  logic                  busy;

  int check_count = 0;
  int fail_count  = 0;
  int rx_count    = 0;
  int read_empty_viol = 0;

  logic [31:0]        fifo_q[$];
  logic signed [63:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_requant_drain #(
    .D_W(D_W), .M_W(M_W), .O_W(O_W), .OQ_DEPTH(OQ_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .cfg_mult   (cfg_mult),
    .cfg_shift  (cfg_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // Upstream FIFO model: data appears the cycle after a pop, empty flag is registered.
  always @(posedge clk) begin
    if (fifo_read && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (fifo_read && fifo_empty) read_empty_viol++;
    if (out_valid && out_ready) begin
      rx_count++;
      if (exp_q.size() == 0) checkOutput("unexpected_out", 1, 0);
      else checkOutput("out_data", $signed(out_data), exp_q.pop_front());
    end
  end

  function automatic logic signed [63:0] requant(input longint d, input int m, input int s);
    longint p;
    longint r;
    p = d * longint'(m);
    if (s == 0) r = p;
    else r = (p + (longint'(1) << (s - 1))) >>> s;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return r;
  endfunction

  task automatic applyStimulus(input logic signed [31:0] d, input logic signed [63:0] e);
    fifo_q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit isIdle();
    return !busy && fifo_empty && fifo_q.size() == 0 && exp_q.size() == 0;
  endfunction

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (!isIdle() && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput({tag, "_drained"}, (n < budget) ? 1 : 0, 1);
  endtask

  task automatic waitPop(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (!fifo_read && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_pop_seen"}, fifo_read, 1);
  endtask

  initial begin
    int rx0;
    int pops;
    int cnt;
    int run;
    logic signed [31:0] d;

    rst       = 1'b1;
    out_ready = 1'b0;
    cfg_mult  = 16'd1;
    cfg_shift = 5'd1;
    nextCycle();

    // Reset held with a non-empty FIFO: nothing may be popped or presented.
    applyStimulus(100, 50);
    applyStimulus(-100, -50);
    nextCycle();
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_fifo_empty_low", fifo_empty, 0);
      checkOutput("rst_fifo_read", fifo_read, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_out_data", $signed(out_data), 0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;

    // Basic transfer and drain latency.
    rx0 = rx_count;
    waitPop("basic", 20);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("basic_latency", cnt, 3);
    waitIdle("basic", 50);
    checkOutput("basic_rx", rx_count - rx0, 2);

    // Rounding ties and saturation at both rails.
    rx0 = rx_count;
    applyStimulus(3, 2);
    applyStimulus(-3, -1);
    applyStimulus(1000, 127);
    applyStimulus(-1000, -128);
    waitIdle("round", 50);
    checkOutput("round_rx", rx_count - rx0, 4);

    // Backpressure: only OQ_DEPTH pops may be issued while the sink is stalled.
    $display("[TB] backpressure phase");
    cfg_mult  = 16'd1;
    cfg_shift = 5'd0;
    out_ready = 1'b0;
    rx0 = rx_count;
    for (int i = 0; i < 10; i++) applyStimulus(10 * i - 45, 10 * i - 45);
    pops = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_read) pops++;
    end
    checkOutput("bp_pops", pops, OQ_DEPTH);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_busy", busy, 1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_hold_data", $signed(out_data), -45);
    end
    nextCycle();
    out_ready = 1'b1;
    waitIdle("bp", 100);
    checkOutput("bp_rx", rx_count - rx0, 10);

    // Streaming at full rate: 64 consecutive pops.
    $display("[TB] streaming phase");
    cfg_mult  = 16'd3;
    cfg_shift = 5'd2;
    rx0 = rx_count;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 1) d = $urandom;
      else d = int'($urandom_range(0, 1000)) - 500;
      applyStimulus(d, requant(longint'(d), 3, 2));
    end
    waitPop("stream", 20);
    run = 1;
    repeat (63) begin
      @(negedge clk);
      if (fifo_read) run++;
    end
    checkOutput("stream_consecutive_pops", run, 64);
    waitIdle("stream", 200);
    checkOutput("stream_rx", rx_count - rx0, 64);

    // Random sink readiness: order and content still tracked by the scoreboard.
    rx0 = rx_count;
    for (int i = 0; i < 64; i++) begin
      d = int'($urandom_range(0, 400)) - 200;
      applyStimulus(d, requant(longint'(d), 3, 2));
    end
    cnt = 0;
    while (!isIdle() && cnt < 2000) begin
      nextCycle();
      out_ready = ($urandom_range(0, 1) == 1);
      cnt++;
    end
    checkOutput("random_ready_drained", (cnt < 2000) ? 1 : 0, 1);
    checkOutput("random_ready_rx", rx_count - rx0, 64);
    out_ready = 1'b1;

    // Reset mid-stream with words both in the pipe and in the queue.
    $display("[TB] mid-stream reset phase");
    cfg_mult  = 16'd1;
    cfg_shift = 5'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(i + 1, i + 1);
    waitPop("midrst", 20);
    repeat (4) nextCycle();
    checkOutput("midrst_busy_before", busy, 1);
    checkOutput("midrst_valid_before", out_valid, 1);
    checkOutput("midrst_head_before", $signed(out_data), 1);
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    nextCycle();
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_fifo_read", fifo_read, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    rx0 = rx_count;
    applyStimulus(5, 5);
    applyStimulus(-7, -7);
    applyStimulus(127, 127);
    applyStimulus(200, 127);
    applyStimulus(-129, -128);
    waitIdle("postrst", 50);
    checkOutput("postrst_rx", rx_count - rx0, 5);

    checkOutput("read_while_empty", read_empty_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
